// File: rtl/gtx_rx_framer_if.sv
// Bundle of the receive word stream from the transceiver and the framed payload/status outputs.
// The slave side is the framer; the master side is whatever feeds the channel and consumes payload.
interface gtx_rx_framer_if #(
   parameter int DATA_WIDTH = 20
);
   logic [DATA_WIDTH-1:0] gt_rxdata;
   logic                  rxbyteisaligned;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  sof;
   logic                  locked;
   logic                  lock_loss;
   logic [15:0]           frame_cnt;
   logic [15:0]           sync_err_cnt;

   modport master (
      output gt_rxdata, rxbyteisaligned,
      input  data_out, data_valid, sof, locked, lock_loss, frame_cnt, sync_err_cnt
   );

   modport slave (
      input  gt_rxdata, rxbyteisaligned,
      output data_out, data_valid, sof, locked, lock_loss, frame_cnt, sync_err_cnt
   );
endinterface

// File: rtl/gtx_rx_framer.sv
// Frame synchroniser for a transceiver receive channel: hunts for the sync word, verifies it over
// several frames, then delivers payload with a flywheel that tolerates a few corrupted sync slots.
module gtx_rx_framer #(
   parameter int                    DATA_WIDTH = 20,
   parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 20'h5F0A3,
   parameter int                    FRAME_LEN  = 16,
   parameter int                    LOCK_CNT   = 3,
   parameter int                    UNLOCK_CNT = 4
) (
   input logic            rxusrclk,
   input logic            reset_n,
   gtx_rx_framer_if.slave rx
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int               POS_W    = $clog2(FRAME_LEN);
   localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
   localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_CNT);

   logic [1:0]            rst_sync_q;
   logic                  rst_int_n;

   state_t                state_q, state_d;
   logic [POS_W-1:0]      pos_q, pos_d, pos_inc;
   logic [3:0]            good_q, good_d;
   logic [3:0]            miss_q, miss_d;
   logic [DATA_WIDTH-1:0] rxdata_d1_q, rxdata_d1_d;
   logic                  aligned_d1_q, aligned_d1_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic                  sof_q, sof_d;
   logic                  locked_q, locked_d;
   logic                  lock_loss_q, lock_loss_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic [15:0]           sync_err_cnt_q, sync_err_cnt_d;
   logic                  sync_hit;

   // Reset asserts immediately but releases only after two clean rxusrclk edges.
   always_ff @(posedge rxusrclk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   // Input stage, framer state and registered outputs.
   always_ff @(posedge rxusrclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q        <= HUNT;
         pos_q          <= POS_ZERO;
         good_q         <= 4'd0;
         miss_q         <= 4'd0;
         rxdata_d1_q    <= {DATA_WIDTH{1'b0}};
         aligned_d1_q   <= 1'b0;
         data_out_q     <= {DATA_WIDTH{1'b0}};
         data_valid_q   <= 1'b0;
         sof_q          <= 1'b0;
         locked_q       <= 1'b0;
         lock_loss_q    <= 1'b0;
         frame_cnt_q    <= 16'd0;
         sync_err_cnt_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         pos_q          <= pos_d;
         good_q         <= good_d;
         miss_q         <= miss_d;
         rxdata_d1_q    <= rxdata_d1_d;
         aligned_d1_q   <= aligned_d1_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         sof_q          <= sof_d;
         locked_q       <= locked_d;
         lock_loss_q    <= lock_loss_d;
         frame_cnt_q    <= frame_cnt_d;
         sync_err_cnt_q <= sync_err_cnt_d;
      end
   end

   // Next-state and output decode, evaluated on the d1 word.
   always_comb begin
      rxdata_d1_d    = rx.gt_rxdata;
      aligned_d1_d   = rx.rxbyteisaligned;
      state_d        = state_q;
      pos_d          = pos_q;
      good_d         = good_q;
      miss_d         = miss_q;
      data_out_d     = data_out_q;
      data_valid_d   = 1'b0;
      sof_d          = 1'b0;
      lock_loss_d    = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      sync_err_cnt_d = sync_err_cnt_q;
      sync_hit       = (rxdata_d1_q == SYNC_WORD);
      pos_inc        = (pos_q == POS_LAST) ? POS_ZERO : (pos_q + POS_ONE);

      // Losing byte alignment overrides every sync decision on the same word.
      if (!aligned_d1_q) begin
         state_d     = HUNT;
         pos_d       = POS_ZERO;
         good_d      = 4'd0;
         miss_d      = 4'd0;
         lock_loss_d = (state_q == LOCKED);
      end else begin
         case (state_q)
            HUNT: begin
               if (sync_hit) begin
                  good_d  = 4'd1;
                  pos_d   = POS_ONE;
                  state_d = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
               end else begin
                  pos_d = POS_ZERO;
               end
            end
            VERIFY: begin
               pos_d = pos_inc;
               if (pos_q != POS_ZERO) begin
                  state_d = VERIFY;
               end else if (!sync_hit) begin
                  state_d = HUNT;
                  pos_d   = POS_ZERO;
                  good_d  = 4'd0;
               end else begin
                  good_d  = good_q + 4'd1;
                  state_d = ((good_q + 4'd1) == LOCK_N) ? LOCKED : VERIFY;
               end
            end
            LOCKED: begin
               pos_d = pos_inc;
               if (pos_q != POS_ZERO) begin
                  data_valid_d = 1'b1;
                  data_out_d   = rxdata_d1_q;
                  if (pos_q == POS_ONE) begin
                     sof_d       = 1'b1;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                  end else begin
                     sof_d = 1'b0;
                  end
               end else if (sync_hit) begin
                  miss_d = 4'd0;
               end else begin
                  miss_d = miss_q + 4'd1;
                  if (sync_err_cnt_q != 16'hFFFF) begin
                     sync_err_cnt_d = sync_err_cnt_q + 16'd1;
                  end else begin
                     sync_err_cnt_d = sync_err_cnt_q;
                  end
                  // Last tolerated miss exhausted: drop lock before this frame's payload arrives.
                  if ((miss_q + 4'd1) == UNLOCK_N) begin
                     state_d     = HUNT;
                     pos_d       = POS_ZERO;
                     good_d      = 4'd0;
                     miss_d      = 4'd0;
                     lock_loss_d = 1'b1;
                  end else begin
                     state_d = LOCKED;
                  end
               end
            end
            default: begin
               state_d = HUNT;
               pos_d   = POS_ZERO;
               good_d  = 4'd0;
               miss_d  = 4'd0;
            end
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   assign rx.data_out     = data_out_q;
   assign rx.data_valid   = data_valid_q;
   assign rx.sof          = sof_q;
   assign rx.locked       = locked_q;
   assign rx.lock_loss    = lock_loss_q;
   assign rx.frame_cnt    = frame_cnt_q;
   assign rx.sync_err_cnt = sync_err_cnt_q;

endmodule

// File: tb/tb_gtx_rx_framer.sv
// Frame-level bench for gtx_rx_framer: a table of frames with expected status, a payload scoreboard,
// and hand-written sequences for false sync, alignment drop and mid-frame reset.
module tb_gtx_rx_framer;
   localparam int             DW   = 20;
   localparam int             FL   = 16;
   localparam logic [DW-1:0]  SYNC = 20'h5F0A3;
   localparam logic [DW-1:0]  BAD  = 20'h12345;
   localparam logic [DW-1:0]  IDLE = 20'h00000;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sof;
   } exp_t;

   typedef struct {
      logic        good_sync;
      logic        deliver;
      logic        locked;
      logic [15:0] err;
      logic [15:0] fcnt;
      int          loss;
   } frame_vec_t;

   logic rxusrclk;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   loss_seen = 0;
   exp_t exp_q[$];
   frame_vec_t vecs[17];

   gtx_rx_framer_if #(.DATA_WIDTH(DW)) rx ();

   gtx_rx_framer #(
      .DATA_WIDTH(DW), .SYNC_WORD(SYNC), .FRAME_LEN(FL), .LOCK_CNT(3), .UNLOCK_CNT(4)
   ) dut (
      .rxusrclk(rxusrclk),
      .reset_n (reset_n),
      .rx      (rx)
   );

   initial begin
      rxusrclk = 1'b0;
      forever #5 rxusrclk = ~rxusrclk;
   end

   function automatic logic [DW-1:0] payload(input int tag, input int idx);
      logic [7:0] t;
      logic [7:0] k;
      t = tag[7:0];
      k = idx[7:0];
      return {4'hA, t, k};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [DW-1:0] d, input logic a);
      rx.gt_rxdata       = d;
      rx.rxbyteisaligned = a;
      @(posedge rxusrclk);
      #1;
   endtask

   task automatic drive_frame(input logic good_sync, input logic deliver, input int tag);
      logic [DW-1:0] w;
      step(good_sync ? SYNC : BAD, 1'b1);
      for (int i = 1; i < FL; i++) begin
         w = payload(tag, i);
         if (deliver) exp_q.push_back({w, (i == 1) ? 1'b1 : 1'b0});
         step(w, 1'b1);
      end
   endtask

   // Payload monitor: every valid word must match the head of the scoreboard.
   always begin
      exp_t e;
      @(posedge rxusrclk);
      #2;
      if (rx.lock_loss === 1'b1) loss_seen++;
      if (rx.data_valid === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: data_out=%h sof=%b, no word expected", rx.data_out, rx.sof);
         end else begin
            e = exp_q.pop_front();
            if ({rx.data_out, rx.sof} !== e) begin
               n_fail++;
               $display("FAIL payload: got data=%h sof=%b expected data=%h sof=%b",
                        rx.data_out, rx.sof, e.data, e.sof);
            end
         end
      end else if (rx.sof !== 1'b0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sof_without_valid: sof=%b data_valid=%b", rx.sof, rx.data_valid);
      end
   end

   initial begin
      logic [DW-1:0] w;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd0,  0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd0,  0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'd0, 16'd1,  0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'd0, 16'd2,  0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'd1, 16'd3,  0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'd1, 16'd4,  0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'd2, 16'd5,  0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'd3, 16'd6,  0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'd4, 16'd7,  0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'd4, 16'd8,  0};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 16'd5, 16'd9,  0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 16'd6, 16'd10, 0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 16'd7, 16'd11, 0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 16'd8, 16'd11, 1};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 16'd8, 16'd11, 0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 16'd8, 16'd11, 0};
      vecs[16] = '{1'b1, 1'b1, 1'b1, 16'd8, 16'd12, 0};

      rx.gt_rxdata       = IDLE;
      rx.rxbyteisaligned = 1'b0;
      reset_n            = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) step(IDLE, 1'b1);
      chk("rst_data_out",   32'(rx.data_out), 32'd0);
      chk("rst_data_valid", 32'(rx.data_valid), 32'd0);
      chk("rst_locked",     32'(rx.locked), 32'd0);
      chk("rst_frame_cnt",  32'(rx.frame_cnt), 32'd0);
      chk("rst_sync_err",   32'(rx.sync_err_cnt), 32'd0);
      reset_n = 1'b1;
      repeat (4) step(IDLE, 1'b1);

      for (int r = 0; r < 17; r++) begin
         loss_seen = 0;
         drive_frame(vecs[r].good_sync, vecs[r].deliver, r);
         chk($sformatf("tbl%0d_locked", r),    32'(rx.locked), 32'(vecs[r].locked));
         chk($sformatf("tbl%0d_sync_err", r),  32'(rx.sync_err_cnt), 32'(vecs[r].err));
         chk($sformatf("tbl%0d_frame_cnt", r), 32'(rx.frame_cnt), 32'(vecs[r].fcnt));
         chk($sformatf("tbl%0d_lock_loss", r), 32'(loss_seen), 32'(vecs[r].loss));
      end

      // Alignment drops for one word in the middle of a locked frame.
      loss_seen = 0;
      step(SYNC, 1'b1);
      for (int i = 1; i < FL; i++) begin
         w = payload(20, i);
         if (i < 6) begin
            exp_q.push_back({w, (i == 1) ? 1'b1 : 1'b0});
            step(w, 1'b1);
         end else begin
            step(w, (i != 6) ? 1'b1 : 1'b0);
         end
      end
      chk("align_lock_loss", 32'(loss_seen), 32'd1);
      chk("align_locked",    32'(rx.locked), 32'd0);
      drive_frame(1'b1, 1'b0, 21);
      drive_frame(1'b1, 1'b0, 22);
      drive_frame(1'b1, 1'b1, 23);
      chk("align_relock",    32'(rx.locked), 32'd1);
      chk("align_frame_cnt", 32'(rx.frame_cnt), 32'd14);

      // False sync inside payload while hunting.
      loss_seen = 0;
      step(IDLE, 1'b0);
      for (int i = 1; i < FL; i++) step((i == 5) ? SYNC : payload(30, i), 1'b1);
      chk("false_drop_loss",  32'(loss_seen), 32'd1);
      chk("false_verify_lck", 32'(rx.locked), 32'd0);
      loss_seen = 0;
      drive_frame(1'b1, 1'b0, 31);
      chk("false_reject_lck",  32'(rx.locked), 32'd0);
      chk("false_reject_loss", 32'(loss_seen), 32'd0);
      drive_frame(1'b1, 1'b0, 32);
      drive_frame(1'b1, 1'b0, 33);
      chk("false_pre_lock", 32'(rx.locked), 32'd0);
      drive_frame(1'b1, 1'b1, 34);
      chk("false_relock",    32'(rx.locked), 32'd1);
      chk("false_frame_cnt", 32'(rx.frame_cnt), 32'd15);
      chk("false_sync_err",  32'(rx.sync_err_cnt), 32'd8);

      // Reset pulsed mid-frame while locked; outputs must clear without a clock edge.
      step(SYNC, 1'b1);
      for (int i = 1; i < 8; i++) begin
         w = payload(40, i);
         exp_q.push_back({w, (i == 1) ? 1'b1 : 1'b0});
         step(w, 1'b1);
      end
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_data_out",   32'(rx.data_out), 32'd0);
      chk("mrst_data_valid", 32'(rx.data_valid), 32'd0);
      chk("mrst_sof",        32'(rx.sof), 32'd0);
      chk("mrst_locked",     32'(rx.locked), 32'd0);
      chk("mrst_lock_loss",  32'(rx.lock_loss), 32'd0);
      chk("mrst_frame_cnt",  32'(rx.frame_cnt), 32'd0);
      chk("mrst_sync_err",   32'(rx.sync_err_cnt), 32'd0);
      exp_q.delete();
      for (int i = 8; i < FL; i++) begin
         if (i == 11) reset_n = 1'b1;
         step(payload(40, i), 1'b1);
      end
      chk("mrst_post_fcnt",   32'(rx.frame_cnt), 32'd0);
      chk("mrst_post_locked", 32'(rx.locked), 32'd0);
      drive_frame(1'b1, 1'b0, 41);
      drive_frame(1'b1, 1'b0, 42);
      chk("mrst_pre_lock", 32'(rx.locked), 32'd0);
      drive_frame(1'b1, 1'b1, 43);
      chk("mrst_relock",    32'(rx.locked), 32'd1);
      chk("mrst_frame_cnt", 32'(rx.frame_cnt), 32'd1);
      chk("mrst_sync_err",  32'(rx.sync_err_cnt), 32'd0);

      repeat (4) step(IDLE, 1'b0);
      chk("pending_words", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
